// File: rtl/tpi_bus_sequencer.sv
// tpi_bus_sequencer: arbitrates one TPI register bus between the CPU (priority, one-deep pending slot) and an aux requester, one-clock cs_n per access.
//   clk_i/reset_i          clock, synchronous active-high reset
//   cpu_strobe_i/rw/rs/wdata  CPU bus cycle request (one-clk pulse)
//   cpu_rdata_o/rvalid_o   CPU read result and completion pulse; cpu_ovr_o sticky lost-strobe flag
//   aux_req_i/rw/rs/wdata/safe  aux level request, held until aux_ack_o
//   aux_ack_o/rdata_o/err_o     aux completion pulse, read data, refusal flag
//   tpi_cs_n_o/rw_o/rs_o/db_in_o  registered TPI bus; tpi_db_out_i registered read data from the TPI
module tpi_bus_sequencer #(
  parameter logic [7:0] SIDE_EFFECT_MASK = 8'b1000_0001
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       cpu_strobe_i,
  input  logic       cpu_rw_i,
  input  logic [2:0] cpu_rs_i,
  input  logic [7:0] cpu_wdata_i,
  output logic [7:0] cpu_rdata_o,
  output logic       cpu_rvalid_o,
  output logic       cpu_ovr_o,
  input  logic       aux_req_i,
  input  logic       aux_rw_i,
  input  logic [2:0] aux_rs_i,
  input  logic [7:0] aux_wdata_i,
  input  logic       aux_safe_i,
  output logic       aux_ack_o,
  output logic [7:0] aux_rdata_o,
  output logic       aux_err_o,
  output logic       tpi_cs_n_o,
  output logic       tpi_rw_o,
  output logic [2:0] tpi_rs_o,
  output logic [7:0] tpi_db_in_o,
  input  logic [7:0] tpi_db_out_i
);
  typedef enum logic [2:0] {IDLE, ACCESS, WAIT, COMPLETE, REFUSE} state_t;
  state_t     state_q;
  logic       pend_q, pend_rw_q, owner_aux_q;
  logic [2:0] pend_rs_q;
  logic [7:0] pend_wdata_q;
  logic       cpu_rvalid_q, cpu_ovr_q, aux_ack_q, aux_err_q, tpi_cs_n_q, tpi_rw_q;
  logic [7:0] cpu_rdata_q, aux_rdata_q, tpi_db_in_q;
  logic [2:0] tpi_rs_q;
  logic       idle_d, cpu_req_d, aux_refuse_d, sel_rw_d;
  logic [2:0] sel_rs_d;
  logic [7:0] sel_wdata_d;
  // A pending CPU request is always older than a same-clock strobe, so it is served first.
  always_comb begin
    idle_d       = state_q == IDLE;
    cpu_req_d    = cpu_strobe_i | pend_q;
    sel_rw_d     = pend_q ? pend_rw_q : cpu_rw_i;
    sel_rs_d     = pend_q ? pend_rs_q : cpu_rs_i;
    sel_wdata_d  = pend_q ? pend_wdata_q : cpu_wdata_i;
    aux_refuse_d = aux_safe_i & aux_rw_i & SIDE_EFFECT_MASK[aux_rs_i];
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      pend_q       <= 1'b0;
      pend_rw_q    <= 1'b0;
      pend_rs_q    <= '0;
      pend_wdata_q <= '0;
      owner_aux_q  <= 1'b0;
      cpu_rdata_q  <= '0;
      cpu_rvalid_q <= 1'b0;
      cpu_ovr_q    <= 1'b0;
      aux_ack_q    <= 1'b0;
      aux_err_q    <= 1'b0;
      aux_rdata_q  <= '0;
      tpi_cs_n_q   <= 1'b1;
      tpi_rw_q     <= 1'b1;
      tpi_rs_q     <= '0;
      tpi_db_in_q  <= '0;
    end else begin
      cpu_rvalid_q <= 1'b0;
      aux_ack_q    <= 1'b0;
      aux_err_q    <= 1'b0;
      tpi_cs_n_q   <= 1'b1;
      // In IDLE the slot drains into the access and refills from a same-clock strobe; elsewhere it only fills.
      pend_q <= idle_d ? pend_q & cpu_strobe_i : pend_q | cpu_strobe_i;
      if (cpu_strobe_i && (idle_d || !pend_q)) begin
        pend_rw_q    <= cpu_rw_i;
        pend_rs_q    <= cpu_rs_i;
        pend_wdata_q <= cpu_wdata_i;
      end
      if (cpu_strobe_i && !idle_d && pend_q) cpu_ovr_q <= 1'b1;
      case (state_q)
        IDLE:
          if (cpu_req_d) begin
            state_q     <= ACCESS;
            owner_aux_q <= 1'b0;
            tpi_cs_n_q  <= 1'b0;
            tpi_rw_q    <= sel_rw_d;
            tpi_rs_q    <= sel_rs_d;
            tpi_db_in_q <= sel_wdata_d;
          end else if (aux_req_i && aux_refuse_d) begin
            state_q   <= REFUSE;
            aux_ack_q <= 1'b1;
            aux_err_q <= 1'b1;
          end else if (aux_req_i) begin
            state_q     <= ACCESS;
            owner_aux_q <= 1'b1;
            tpi_cs_n_q  <= 1'b0;
            tpi_rw_q    <= aux_rw_i;
            tpi_rs_q    <= aux_rs_i;
            tpi_db_in_q <= aux_wdata_i;
          end
        ACCESS: state_q <= WAIT;
        // Results are loaded on entry to COMPLETE so the registered pulses are visible during COMPLETE.
        WAIT: begin
          state_q <= COMPLETE;
          if (owner_aux_q) begin
            aux_ack_q <= 1'b1;
            if (tpi_rw_q) aux_rdata_q <= tpi_db_out_i;
          end else begin
            cpu_rvalid_q <= 1'b1;
            if (tpi_rw_q) cpu_rdata_q <= tpi_db_out_i;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign cpu_rdata_o  = cpu_rdata_q;
  assign cpu_rvalid_o = cpu_rvalid_q;
  assign cpu_ovr_o    = cpu_ovr_q;
  assign aux_ack_o    = aux_ack_q;
  assign aux_rdata_o  = aux_rdata_q;
  assign aux_err_o    = aux_err_q;
  assign tpi_cs_n_o   = tpi_cs_n_q;
  assign tpi_rw_o     = tpi_rw_q;
  assign tpi_rs_o     = tpi_rs_q;
  assign tpi_db_in_o  = tpi_db_in_q;
endmodule

// File: doc/tpi_bus_sequencer.md
Name: tpi_bus_sequencer

Overview:
- Sequences and arbitrates the register bus of one 6523/6525 TPI instance between two requesters: the 6509 CPU bus and an auxiliary requester (OSD keyboard injector or state inspector).
- Every TPI access is a single-clock `cs_n` pulse, because TPI read side effects act on every clock that `cs_n` is low (port A read clears/pulses CA; AIR read pops the interrupt stack).
- The block registers TPI read data and returns it to the owning requester.
- The CPU has strict priority. Aux accesses fill idle slots.

Parameters:
- `SIDE_EFFECT_MASK`, default `8'b1000_0001`: bit n=1 marks a read of rs=n as side-effecting. Used only when `aux_safe`=1.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `cpu_strobe` in 1: one-clk pulse per CPU bus cycle that selects this TPI.
- `cpu_rw` in 1: 1=read, 0=write. Valid with `cpu_strobe`.
- `cpu_rs` in 3: register select. Valid with `cpu_strobe`.
- `cpu_wdata` in 8: write data. Valid with `cpu_strobe`.
- `cpu_rdata` out 8: last CPU read result.
- `cpu_rvalid` out 1: one-clk pulse when `cpu_rdata` is updated.
- `cpu_ovr` out 1: sticky; a CPU strobe was lost.
- `aux_req` in 1: level request. `aux_rw`/`aux_rs`/`aux_wdata`/`aux_safe` are held stable while it is high.
- `aux_rw` in 1: aux direction (1=read).
- `aux_rs` in 3: aux register select.
- `aux_wdata` in 8: aux write data.
- `aux_safe` in 1: 1 = refuse side-effecting reads.
- `aux_ack` out 1: one-clk completion pulse.
- `aux_rdata` out 8: aux read result. Valid with `aux_ack`.
- `aux_err` out 1: with `aux_ack`; the access was refused and not performed.
- `tpi_cs_n` out 1: to TPI `cs_n`.
- `tpi_rw` out 1: to TPI `rw`.
- `tpi_rs` out 3: to TPI `rs`.
- `tpi_db_in` out 8: to TPI `db_in`.
- `tpi_db_out` in 8: from TPI `db_out`, which is registered inside the TPI.

Behaviour:
- Reset values: `tpi_cs_n`=1, `tpi_rw`=1, `tpi_rs`=0, `tpi_db_in`=0, `cpu_rdata`=0, `cpu_rvalid`=0, `cpu_ovr`=0, `aux_ack`=0, `aux_err`=0, `aux_rdata`=0. FSM state = IDLE. Pending slot and owner cleared.
- Reset mid-access: the access is abandoned, no ack or valid pulse is generated, and `tpi_cs_n` is 1 from the next clock.
- All `tpi_*` outputs are registered. `tpi_cs_n` is low for exactly one clock per access, never two in a row.
- FSM states and transitions:
  - IDLE → ACCESS (owner=CPU) if a CPU request is present (`cpu_strobe` this clock or pending slot set). `tpi_*` outputs are loaded from that request.
  - Else IDLE → ACCESS (owner=AUX) if `aux_req`=1 and the request is not refused.
  - Else IDLE → REFUSE if `aux_req`=1, `aux_safe`=1, `aux_rw`=1 and `SIDE_EFFECT_MASK[aux_rs]`=1.
  - ACCESS (`tpi_cs_n`=0 this clock) → WAIT. `tpi_cs_n` returns to 1.
  - WAIT → COMPLETE. `tpi_db_out` now holds the read value.
  - COMPLETE: capture data and signal the owner, then go to IDLE.
    - CPU read: `cpu_rdata` ← `tpi_db_out`, `cpu_rvalid`=1.
    - CPU write: `cpu_rvalid`=1, `cpu_rdata` unchanged.
    - AUX: `aux_ack`=1, `aux_err`=0, `aux_rdata` ← `tpi_db_out` (reads), unchanged (writes).
  - REFUSE: `aux_ack`=1, `aux_err`=1, no TPI access, `aux_rdata` unchanged → IDLE.
- Latency: a strobe accepted at clock edge k gives `cs_n` low in cycle k+1 and the valid/ack pulse in cycle k+3. A refused aux request acks in the cycle after it is sampled.
- CPU strobe while ACCESS/WAIT/COMPLETE/REFUSE: the request is stored in a one-deep pending slot and served at the next IDLE, ahead of aux.
- CPU strobe while the pending slot is already full: the new strobe is dropped and `cpu_ovr`←1. `cpu_ovr` clears only on reset.
- Same-clock `cpu_strobe` and `aux_req` in IDLE: CPU wins. Aux waits; no starvation guard is provided, because CPU strobes are at most one per phi2 period.
- Aux handshake: `aux_req` is sampled only in IDLE. The requester drops `aux_req` in the clock it sees `aux_ack`. If `aux_req` is still high in the next IDLE, that is a new request.
- Aux writes are never refused. Aux reads are never refused when `aux_safe`=0.
- Strobe pulses (`cpu_rvalid`, `aux_ack`, `aux_err`) are one clock wide and default to 0.

Test Plan:
- **CPU write:** after reset, strobe rs=3 wdata=8'hFF → exactly one clock with `tpi_cs_n`=0, `tpi_rw`=0, `tpi_rs`=3, `tpi_db_in`=FF; `cpu_rvalid` pulses 3 clocks after the strobe.
- **CPU read:** TPI model `db_out`=8'h5A, CPU read rs=1 → `cpu_rdata`=5A with `cpu_rvalid` at k+3; `cs_n` is low for exactly one clock, so the model's AIR pop count on an rs=7 read is 1.
- **Same-clock collision:** `cpu_strobe` (read rs=0) and `aux_req` (write rs=4 data 8'h0F) together → CPU access first; aux access `cs_n` follows the CPU COMPLETE; `aux_ack` arrives 4 clocks after the CPU `cpu_rvalid`.
- **Aux refused read:** `aux_safe`=1, aux read rs=7 → `aux_ack`=1 and `aux_err`=1 the next clock, `tpi_cs_n` stays 1; with `aux_safe`=0 the same request reads normally with `aux_err`=0.
- **Overrun:** three CPU strobes on consecutive clocks → first served, second pending then served, third dropped; `cpu_ovr`=1 and exactly 2 `cs_n` pulses.
- **Reset mid-access:** reset asserted during WAIT of an aux read → no `aux_ack`, all outputs at reset values next clock; a new aux request after reset completes normally.
